// File: rtl/genpad_pkg.sv
// Shared constants for the Genesis pad emulator and the genesis_gamepad decoder.
package genpad_pkg;

  localparam logic [1:0] PAD_SMS = 2'b00;
  localparam logic [1:0] PAD_3B  = 2'b01;
  localparam logic [1:0] PAD_6B  = 2'b10;

  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_A = 4;
  localparam int BTN_B = 5;
  localparam int BTN_C = 6;
  localparam int BTN_S = 7;
  localparam int BTN_M = 8;
  localparam int BTN_X = 9;
  localparam int BTN_Y = 10;
  localparam int BTN_Z = 11;

  localparam int DEFAULT_TIMEOUT = 75000;

endpackage

// File: rtl/genpad_sel_sync.sv
// Two-flop synchronizer for the console select line plus a level-change detector.
module genpad_sel_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sel,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Select is pulled up when idle, so every flop resets high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sel  = r_sync;
  assign o_edge = r_sync ^ r_prev;

endmodule

// File: rtl/genesis_pad_emulator.sv
// Emulates SMS / 3-button / 6-button Genesis pad output lines driven by the
// console select line, including the 6-button phase counter and its idle timeout.
module genesis_pad_emulator
  import genpad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [1:0]  iPADTYPE,
  input  logic [11:0] iBUTTONS,
  input  logic        iSELECT,
  output logic [5:0]  oGENPAD
);

  localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  function automatic logic [5:0] pad_map(input logic [1:0]  pad,
                                         input logic        sel,
                                         input logic [2:0]  ph,
                                         input logic [11:0] b);
    logic [5:0] m_sms;
    logic [5:0] m_3b;
    logic [5:0] res;
    m_sms = ~{b[BTN_C], b[BTN_B], b[BTN_U], b[BTN_D], b[BTN_L], b[BTN_R]};
    m_3b  = sel ? m_sms : {~b[BTN_S], ~b[BTN_A], ~b[BTN_U], ~b[BTN_D], 2'b00};
    res   = m_sms;
    case (pad)
      PAD_3B: res = m_3b;
      PAD_6B: begin
        if (sel && ph == 3'd6)
          res = ~{b[BTN_C], b[BTN_B], b[BTN_Z], b[BTN_Y], b[BTN_X], b[BTN_M]};
        else if (!sel && ph == 3'd5)
          res = {~b[BTN_S], ~b[BTN_A], 4'b0000};
        else if (!sel && ph == 3'd7)
          res = {~b[BTN_S], ~b[BTN_A], 4'b1111};
        else
          res = m_3b;
      end
      default: res = m_sms;
    endcase
    return res;
  endfunction

  logic              w_sel;
  logic              w_edge;
  logic              w_pad_chg;
  logic [2:0]        w_phase_nxt;
  logic [IDLE_W-1:0] w_idle_nxt;

  logic [2:0]        r_phase;
  logic [IDLE_W-1:0] r_idle;
  logic [1:0]        r_pad_prev;
  logic [5:0]        r_genpad;

  genpad_sel_sync u_sel_sync (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_async (iSELECT),
    .o_sel   (w_sel),
    .o_edge  (w_edge)
  );

  assign w_pad_chg = (iPADTYPE != r_pad_prev);

  // Pad-type change beats select edge, which beats the idle timeout.
  always_comb begin
    w_phase_nxt = r_phase;
    w_idle_nxt  = r_idle;
    if (w_pad_chg) begin
      w_phase_nxt = 3'd0;
      w_idle_nxt  = '0;
    end else if (w_edge) begin
      w_phase_nxt = r_phase + 3'd1;
      w_idle_nxt  = '0;
    end else begin
      if (r_idle != IDLE_MAX)
        w_idle_nxt = r_idle + 1'b1;
      if (w_idle_nxt == IDLE_MAX)
        w_phase_nxt = 3'd0;
    end
  end

  // Output uses the post-update phase so a select edge reaches the pins in 3 cycles.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_phase    <= 3'd0;
      r_idle     <= '0;
      r_pad_prev <= iPADTYPE;
      r_genpad   <= 6'b111111;
    end else begin
      r_phase    <= w_phase_nxt;
      r_idle     <= w_idle_nxt;
      r_pad_prev <= iPADTYPE;
      r_genpad   <= pad_map(iPADTYPE, w_sel, w_phase_nxt, iBUTTONS);
    end
  end

  assign oGENPAD = r_genpad;

endmodule

// File: tb/tb_genesis_pad_emulator.sv
// Directed bench for genesis_pad_emulator: vector table for static mappings,
// hand-written sequences for 6-button phases, timeout, pad change and reset.
module tb_genesis_pad_emulator;
  import genpad_pkg::*;

  localparam int TO = 1000;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [1:0]  iPADTYPE = PAD_SMS;
  logic [11:0] iBUTTONS = 12'hFFF;
  logic        iSELECT = 1'b1;
  logic [5:0]  oGENPAD;

  int checks = 0;
  int errors = 0;

  genesis_pad_emulator #(.TIMEOUT_CYCLES(TO)) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iPADTYPE (iPADTYPE),
    .iBUTTONS (iBUTTONS),
    .iSELECT  (iSELECT),
    .oGENPAD  (oGENPAD)
  );

  always #10 iCLK = ~iCLK;

  typedef struct {
    logic [1:0]  pad;
    logic [11:0] btn;
    logic        sel;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[12];

  task automatic step(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] exp);
    checks++;
    if (oGENPAD !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, oGENPAD, exp);
    end
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    step(3);
    iRST = 1'b0;
    step(1);
  endtask

  // Toggle select, check the pad after the sync latency, then finish the gap.
  task automatic edge_check(input string name, input logic [5:0] exp, input int gap);
    iSELECT = ~iSELECT;
    step(4);
    check(name, exp);
    step(gap - 4);
  endtask

  task automatic start_6b();
    iPADTYPE = PAD_6B;
    iBUTTONS = 12'hA00;
    iSELECT  = 1'b1;
    do_reset();
  endtask

  task automatic edges(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      iSELECT = ~iSELECT;
      step(gap);
    end
  endtask

  initial begin
    vecs[0]  = '{PAD_SMS, 12'h060, 1'b1, 6'b001111};
    vecs[1]  = '{PAD_SMS, 12'h060, 1'b0, 6'b001111};
    vecs[2]  = '{PAD_3B,  12'h093, 1'b0, 6'b001100};
    vecs[3]  = '{PAD_3B,  12'h093, 1'b1, 6'b111100};
    vecs[4]  = '{PAD_SMS, 12'h000, 1'b1, 6'b111111};
    vecs[5]  = '{PAD_SMS, 12'h00F, 1'b0, 6'b110000};
    vecs[6]  = '{2'b11,   12'hFFF, 1'b1, 6'b000000};
    vecs[7]  = '{PAD_3B,  12'h003, 1'b1, 6'b111100};
    vecs[8]  = '{PAD_3B,  12'h00C, 1'b0, 6'b110000};
    vecs[9]  = '{PAD_3B,  12'hF00, 1'b0, 6'b111100};
    vecs[10] = '{PAD_3B,  12'h0C0, 1'b0, 6'b011100};
    vecs[11] = '{PAD_3B,  12'h0C0, 1'b1, 6'b011111};

    // Reset state with every button pressed.
    step(2);
    check("reset_idle", 6'b111111);
    iRST = 1'b0;
    step(1);

    for (int i = 0; i < 12; i++) begin
      iPADTYPE = vecs[i].pad;
      iBUTTONS = vecs[i].btn;
      iSELECT  = vecs[i].sel;
      step(4);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Latency: buttons 1 cycle, select exactly 3 cycles.
    iPADTYPE = PAD_3B;
    iBUTTONS = 12'h000;
    iSELECT  = 1'b1;
    step(6);
    iBUTTONS = 12'h001;
    step(1);
    check("btn_latency", 6'b111110);
    iBUTTONS = 12'h000;
    step(1);
    iSELECT = 1'b0;
    step(2);
    check("sel_lat_2", 6'b111111);
    step(1);
    check("sel_lat_3", 6'b111100);

    // Full 6-button sequence, 500-cycle gaps.
    start_6b();
    edge_check("seq6_p1", 6'b111100, 500);
    edge_check("seq6_p2", 6'b111111, 500);
    edge_check("seq6_p3", 6'b111100, 500);
    edge_check("seq6_p4", 6'b111111, 500);
    edge_check("seq6_p5", 6'b110000, 500);
    edge_check("seq6_p6", 6'b110101, 500);
    edge_check("seq6_p7", 6'b111111, 500);

    // Timeout returns the phase to 0.
    start_6b();
    edges(4, 20);
    step(TO + 10);
    edge_check("to_p1", 6'b111100, 20);
    edge_check("to_p2", 6'b111111, 20);
    edge_check("to_p3", 6'b111100, 20);

    // Edge landing on the timeout cycle wins.
    start_6b();
    edges(3, 20);
    iSELECT = ~iSELECT;
    step(TO);
    edge_check("edge_at_to", 6'b110000, 20);

    // One cycle later the timeout fires first.
    start_6b();
    edges(3, 20);
    iSELECT = ~iSELECT;
    step(TO + 1);
    edge_check("edge_after_to", 6'b111100, 20);

    // Pad-type change mid-sequence clears the phase.
    start_6b();
    edges(4, 20);
    iPADTYPE = PAD_3B;
    step(4);
    check("padchg_3b", 6'b111111);
    iPADTYPE = PAD_6B;
    step(4);
    edge_check("padchg_p1", 6'b111100, 20);

    // Reset in the middle of the sequence.
    start_6b();
    edges(3, 20);
    iRST = 1'b1;
    step(1);
    check("midrst_a", 6'b111111);
    step(2);
    check("midrst_b", 6'b111111);
    iRST = 1'b0;
    step(4);
    check("postrst_p1", 6'b111100);
    step(16);
    edge_check("postrst_p2", 6'b111111, 20);
    edge_check("postrst_p3", 6'b111100, 20);
    edge_check("postrst_p4", 6'b111111, 20);
    edge_check("postrst_p5", 6'b110000, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
